jtag_scan_master: RTL and testbench

Clock-domain JTAG master that sequences the design's TAP controller: it generates TCK, TMS, TDI and optional TRST_N from the system clock, samples TDO, and runs reset, IR-scan and DR-scan transactions for an on-chip host (self-test or debug logic). It sits between a simple command/response interface and the `tdi`/`tdo`/`tck`/`tms`/`trst_n` pins of the TAP-equipped core, such as the soda machine. Between commands the master always parks the TAP in Run-Test/Idle.

---
 rtl/jtag_scan_master.sv | 225 ++++++++++++++++++++++
 tb/tb_jtag_scan_master.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_master.sv
// JTAG master: turns reset / IR-scan / DR-scan commands into TCK/TMS/TDI sequences and collects TDO.
// Build option: define JTAG_TRST_EN to pulse trst_n low for one TCK period before a TAP reset.
module jtag_scan_master #(
  parameter int MAX_LEN = 32,
  parameter int TCK_DIV = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
  input  logic [MAX_LEN-1:0]           cmd_data,
  output logic                         rsp_valid,
  output logic [MAX_LEN-1:0]           rsp_data,
  output logic                         tck,
  output logic                         tms,
  output logic                         tdi,
  input  logic                         tdo,
  output logic                         trst_n
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int SW = (LW > 3) ? LW : 3;
  localparam int PW = $clog2(2 * TCK_DIV);
  localparam logic [PW-1:0] PH_RISE = PW'(TCK_DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * TCK_DIV - 1);
  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
`ifdef JTAG_TRST_EN
    TRST,
`endif
    PRE,
    SHIFT,
    POST,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [SW-1:0]      len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [PW-1:0]      phase_q, phase_d;
  logic [SW-1:0]      step_q, step_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic [LW-1:0]      len_clamped;
  logic               new_period;
  logic [MAX_LEN-1:0] shift_word;
`ifdef JTAG_TRST_EN
  logic               trst_n_q, trst_n_d;
`endif

  // Index of the final PRE period for each op.
  function automatic logic [SW-1:0] pre_last(input logic [1:0] op);
    case (op)
      OP_RESET: return SW'(5);
      OP_IR:    return SW'(3);
      default:  return SW'(2);
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_d      = len_q;
    data_d     = data_q;
    phase_d    = phase_q;
    step_d     = step_q;
    tck_d      = tck_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    rsp_data_d = rsp_data_q;
    new_period = 1'b0;
`ifdef JTAG_TRST_EN
    trst_n_d   = trst_n_q;
`endif
    len_clamped = (cmd_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d       = cmd_op;
          len_d      = SW'(len_clamped);
          data_d     = cmd_data;
          rsp_data_d = '0;
          phase_d    = '0;
          step_d     = '0;
          tck_d      = 1'b0;
          new_period = 1'b1;
          if (cmd_op == OP_RESET) begin
`ifdef JTAG_TRST_EN
            state_d  = TRST;
            trst_n_d = 1'b0;
`else
            state_d  = PRE;
`endif
          end else if ((cmd_op == OP_IR || cmd_op == OP_DR) && len_clamped != '0) begin
            state_d = PRE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: begin
        // TDO is taken in the first clk cycle with tck high.
        if (state_q == SHIFT && phase_q == PH_RISE)
          rsp_data_d = rsp_data_q | (MAX_LEN'(tdo) << step_q);
        if (phase_q == PH_LAST) begin
          phase_d    = '0;
          tck_d      = 1'b0;
          step_d     = step_q + SW'(1);
          new_period = 1'b1;
          case (state_q)
`ifdef JTAG_TRST_EN
            TRST: begin
              state_d  = PRE;
              step_d   = '0;
              trst_n_d = 1'b1;
            end
`endif
            PRE: begin
              if (step_q == pre_last(op_q)) begin
                step_d  = '0;
                state_d = (op_q == OP_RESET) ? DONE : SHIFT;
              end
            end
            SHIFT: begin
              if (step_q == len_q - SW'(1)) begin
                step_d  = '0;
                state_d = POST;
              end
            end
            POST: begin
              if (step_q == SW'(1)) begin
                step_d  = '0;
                state_d = DONE;
              end
            end
            default: ;
          endcase
        end else begin
          phase_d = phase_q + PW'(1);
          tck_d   = (phase_d >= PH_RISE);
`ifdef JTAG_TRST_EN
          if (state_q == TRST) tck_d = 1'b0;
`endif
        end
      end
    endcase

    // TMS/TDI for the period that starts on the next edge.
    shift_word = data_d >> step_d;
    if (new_period) begin
      tdi_d = 1'b0;
      case (state_d)
`ifdef JTAG_TRST_EN
        TRST: tms_d = 1'b1;
`endif
        PRE: begin
          case (op_d)
            OP_RESET: tms_d = (step_d != SW'(5));
            OP_IR:    tms_d = (step_d < SW'(2));
            default:  tms_d = (step_d == '0);
          endcase
        end
        SHIFT: begin
          tms_d = (step_d == len_d - SW'(1));
          tdi_d = shift_word[0];
        end
        POST:    tms_d = (step_d == '0);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      len_q      <= '0;
      data_q     <= '0;
      phase_q    <= '0;
      step_q     <= '0;
      tck_q      <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      len_q      <= len_d;
      data_q     <= data_d;
      phase_q    <= phase_d;
      step_q     <= step_d;
      tck_q      <= tck_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
      rsp_data_q <= rsp_data_d;
    end
  end

`ifdef JTAG_TRST_EN
  always_ff @(posedge clk) begin
    if (rst) trst_n_q <= 1'b1;
    else     trst_n_q <= trst_n_d;
  end
  assign trst_n = trst_n_q;
`else
  assign trst_n = 1'b1;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = rsp_data_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: a TAP model on the pins plus a per-cycle pin model built from the TMS/TDI rules.
module tb_jtag_scan_master;
  localparam int MAX_LEN = 32;
  localparam int TCK_DIV = 2;
  localparam int P  = 2 * TCK_DIV;
  localparam int LW = $clog2(MAX_LEN + 1);
`ifdef JTAG_TRST_EN
  localparam int RESET_N = 7;
`else
  localparam int RESET_N = 6;
`endif
  localparam logic [3:0] IDCODE = 4'b0001;
  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6, EX2DR = 7,
                 UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PAIR = 13, EX2IR = 14, UPIR = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic cmd_ready, rsp_valid, tck, tms, tdi, trst_n;
  logic tdo = 1'b0;
  logic [MAX_LEN-1:0] rsp_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtag_scan_master #(.MAX_LEN(MAX_LEN), .TCK_DIV(TCK_DIV)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .trst_n(trst_n)
  );

  // ---------------- TAP model (IDCODE 0x1234_5677, 4-bit IR) ----------------
  int tap_state = RTI;
  logic [3:0]  tap_ir = IDCODE;
  logic [3:0]  tap_ir_sr = '0;
  logic [31:0] tap_dr_sr = '0;
  logic        tap_byp = 1'b0;

  function automatic int tap_next(input int s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PADR;
      PADR:  return m ? EX2DR : PADR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PAIR;
      PAIR:  return m ? EX2IR : PAIR;
      EX2IR: return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tap_state <= TLR;
      tap_ir    <= IDCODE;
    end else begin
      case (tap_state)
        CAPDR: begin tap_dr_sr <= 32'h1234_5677; tap_byp <= 1'b0; end
        SHDR:  begin tap_dr_sr <= {tdi, tap_dr_sr[31:1]}; tap_byp <= tdi; end
        CAPIR: tap_ir_sr <= 4'b0001;
        SHIR:  tap_ir_sr <= {tdi, tap_ir_sr[3:1]};
        UPIR:  tap_ir <= tap_ir_sr;
        TLR:   tap_ir <= IDCODE;
        default: ;
      endcase
      tap_state <= tap_next(tap_state, tms);
    end
  end

  always @(negedge tck) begin
    if (tap_state == SHDR)      tdo <= (tap_ir == IDCODE) ? tap_dr_sr[0] : tap_byp;
    else if (tap_state == SHIR) tdo <= tap_ir_sr[0];
  end

  // ---------------- monitors ----------------
  int cyc = 0;
  int rsp_cnt = 0;
  int rsp_cyc_q[$];
  logic [MAX_LEN-1:0] rsp_dat_q[$];
  int rsp_cyc = 0;
  logic [MAX_LEN-1:0] rsp_seen = '0;
  int trst_low_cnt = 0;
  int tck_cnt = 0;
  int tck_total = 0;
  logic [63:0] tms_vec = '0;
  logic [63:0] tdi_vec = '0;

  always @(posedge clk) cyc++;

  always @(posedge tck) begin
    tck_cnt++;
    tck_total++;
    tms_vec = {tms_vec[62:0], tms};
    tdi_vec = {tdi_vec[62:0], tdi};
  end

  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cyc  = cyc + 1;
      rsp_seen = rsp_data;
      rsp_cyc_q.push_back(cyc + 1);
      rsp_dat_q.push_back(rsp_data);
    end
    if (!trst_n) trst_low_cnt++;
  end

  // ---------------- per-cycle pin model ----------------
  typedef struct {
    logic tck;
    logic tms;
    logic tms_chk;
    logic tdi;
    logic tdi_chk;
    logic trst_n;
    logic rsp_valid;
    logic cmd_ready;
  } exp_t;
  exp_t exp_q[$];

  task automatic add_period(input logic t, input logic t_chk, input logic d, input logic d_chk,
                            input logic trst_low);
    for (int c = 0; c < P; c++) begin
      exp_t e;
      e.tck       = trst_low ? 1'b0 : (c >= TCK_DIV);
      e.tms       = t;
      e.tms_chk   = t_chk;
      e.tdi       = d;
      e.tdi_chk   = d_chk;
      e.trst_n    = !trst_low;
      e.rsp_valid = 1'b0;
      e.cmd_ready = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic plan(input logic [1:0] op, input int len_in, input logic [MAX_LEN-1:0] data);
    int len;
    exp_t e;
    len = (len_in > MAX_LEN) ? MAX_LEN : len_in;
    if (op == 2'b00) begin
`ifdef JTAG_TRST_EN
      add_period(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
      for (int i = 0; i < 6; i++) add_period(i != 5, 1'b1, 1'b0, 1'b0, 1'b0);
    end else if ((op == 2'b01 || op == 2'b10) && len > 0) begin
      add_period(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (op == 2'b01) add_period(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      add_period(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      add_period(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < len; i++) add_period(i == len - 1, 1'b1, data[i], 1'b1, 1'b0);
      add_period(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      add_period(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    e.tck = 1'b0; e.tms = 1'b0; e.tms_chk = 1'b0; e.tdi = 1'b0; e.tdi_chk = 1'b0;
    e.trst_n = 1'b1; e.rsp_valid = 1'b1; e.cmd_ready = 1'b0;
    exp_q.push_back(e);
    e.rsp_valid = 1'b0; e.cmd_ready = 1'b1;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (tck !== e.tck || (e.tms_chk && tms !== e.tms) || (e.tdi_chk && tdi !== e.tdi) ||
          trst_n !== e.trst_n || rsp_valid !== e.rsp_valid || cmd_ready !== e.cmd_ready) begin
        failures++;
        $display("FAIL cycle_model t=%0t tck/tms/tdi/trst_n/rsp_valid/cmd_ready got=%b%b%b%b%b%b required=%b%b%b%b%b%b (tms_chk=%b tdi_chk=%b)",
                 $time, tck, tms, tdi, trst_n, rsp_valid, cmd_ready,
                 e.tck, e.tms, e.tdi, e.trst_n, e.rsp_valid, e.cmd_ready, e.tms_chk, e.tdi_chk);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=0x%0h required=0x%0h", name, got, req);
    end
  endtask

  // Called at posedge+1; returns just after the accept edge with e_cyc = cycle count at that edge.
  task automatic do_cmd(input logic [1:0] op, input int len, input logic [MAX_LEN-1:0] data,
                        output int e_cyc);
    int n;
    cmd_op    = op;
    cmd_len   = LW'(len);
    cmd_data  = data;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got cmd_ready=%b required=1", cmd_ready);
    end
    @(posedge clk); #1;
    e_cyc        = cyc;
    cmd_valid    = 1'b0;
    tck_cnt      = 0;
    tms_vec      = '0;
    tdi_vec      = '0;
    trst_low_cnt = 0;
    plan(op, len, data);
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_cnt < target && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (rsp_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout got=%0d responses required=%0d", rsp_cnt, target);
    end
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_pins tck/tms/tdi/trst_n"}, {60'd0, tck, tms, tdi, trst_n}, 64'b0101);
    check({tag, "_ready_valid"}, {62'd0, cmd_ready, rsp_valid}, 64'b10);
    check({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int e, e2, c0, idx, tck0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_pins("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // TAP reset, then IDCODE via 32-bit DR scan
    c0 = rsp_cnt;
    do_cmd(2'b00, 0, '0, e);
    wait_rsp(c0 + 1);
    check("tap_reset_latency", 64'(rsp_cyc - e), 64'(RESET_N * P + 1));
    check("tap_reset_state", 64'(tap_state), 64'(RTI));
    c0 = rsp_cnt;
    do_cmd(2'b10, 32, '0, e);
    wait_rsp(c0 + 1);
    check("idcode_data", 64'(rsp_seen), 64'h1234_5677);
    check("idcode_latency", 64'(rsp_cyc - e), 64'd149);
    check("idcode_periods", 64'(tck_cnt), 64'd37);
    check("idcode_tms", tms_vec, 64'({3'b100, 31'd0, 3'b110}));

    // IR scan of 0xA
    c0 = rsp_cnt;
    do_cmd(2'b01, 4, 32'hA, e);
    wait_rsp(c0 + 1);
    check("ir_rsp", 64'(rsp_seen), 64'h1);
    check("ir_tms", tms_vec, 64'b1100000110);
    check("ir_tdi_shift", {60'd0, tdi_vec[5:2]}, 64'b0101);
    check("ir_latency", 64'(rsp_cyc - e), 64'(10 * P + 1));

    // zero-length DR scan then reserved op, cmd_valid held across
    c0   = rsp_cnt;
    idx  = rsp_cyc_q.size();
    tck0 = tck_total;
    do_cmd(2'b10, 0, 32'hFFFF, e);
    do_cmd(2'b11, 5, 32'h1F, e2);
    wait_rsp(c0 + 2);
    check("zero_len_latency", 64'(rsp_cyc_q[idx] - e), 64'd1);
    check("zero_len_rsp", 64'(rsp_dat_q[idx]), 64'd0);
    check("noop_accept_gap", 64'(e2 - e), 64'd2);
    check("noop_latency", 64'(rsp_cyc_q[idx + 1] - e2), 64'd1);
    check("noop_rsp", 64'(rsp_dat_q[idx + 1]), 64'd0);
    check("noop_no_tck", 64'(tck_total - tck0), 64'd0);

    // TAP reset (with trst_n pulse when that option is built)
    c0 = rsp_cnt;
    do_cmd(2'b00, 0, '0, e);
    wait_rsp(c0 + 1);
    check("reset2_state", 64'(tap_state), 64'(RTI));
    check("reset2_tms", tms_vec, 64'b111110);
    check("reset2_latency", 64'(rsp_cyc - e), 64'(RESET_N * P + 1));
`ifdef JTAG_TRST_EN
    check("trst_low_cycles", 64'(trst_low_cnt), 64'd4);
    check("trst_reset_latency", 64'(rsp_cyc - e), 64'd29);
`else
    check("trst_low_cycles", 64'(trst_low_cnt), 64'd0);
`endif

    // cmd_len above MAX_LEN behaves as MAX_LEN
    c0 = rsp_cnt;
    do_cmd(2'b10, 40, '0, e);
    wait_rsp(c0 + 1);
    check("clamp_data", 64'(rsp_seen), 64'h1234_5677);
    check("clamp_latency", 64'(rsp_cyc - e), 64'd149);
    check("clamp_periods", 64'(tck_cnt), 64'd37);

    // reset asserted during shift bit 10 of a DR scan
    c0 = rsp_cnt;
    do_cmd(2'b10, 32, '0, e);
    repeat (53) begin
      @(posedge clk); #1;
    end
    check("abort_point_periods", 64'(tck_cnt), 64'd13);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check_reset_pins("abort");
    rst = 1'b0;
    repeat (200) begin
      @(posedge clk); #1;
    end
    check("abort_no_rsp", 64'(rsp_cnt), 64'(c0));
    c0 = rsp_cnt;
    do_cmd(2'b00, 0, '0, e);
    wait_rsp(c0 + 1);
    check("recover_state", 64'(tap_state), 64'(RTI));
    c0 = rsp_cnt;
    do_cmd(2'b10, 32, '0, e);
    wait_rsp(c0 + 1);
    check("recover_idcode", 64'(rsp_seen), 64'h1234_5677);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
